regfile_sb: RTL and testbench



---
 rtl/regfile_sb.sv | 123 ++++++++++++
 tb/tb_regfile_sb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two registered read ports,
// one write port with write-to-read bypass, an optional hardwired zero
// register, and a per-register busy scoreboard for RAW hazard detection.
// Every output is a flop; there is no combinational input-to-output path.
module regfile_sb #(
    parameter int WIDTH    = 8,
    parameter int ADDRW    = 3,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADDRW-1:0] readreg1,
    input  logic [ADDRW-1:0] readreg2,
    input  logic             regwrite,
    input  logic [ADDRW-1:0] writereg,
    input  logic [WIDTH-1:0] writedata,
    input  logic             reserve,
    input  logic [ADDRW-1:0] reservereg,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic             busy1,
    output logic             busy2
);

    localparam int DEPTH = 1 << ADDRW;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [WIDTH-1:0] r_data1;
    logic [WIDTH-1:0] r_data2;
    logic             r_busy1;
    logic             r_busy2;

    logic             w_wr_en;
    logic             w_rsv_en;
    logic             w_zero1;
    logic             w_zero2;
    logic [DEPTH-1:0] w_busy_next;
    logic [WIDTH-1:0] w_data1_next;
    logic [WIDTH-1:0] w_data2_next;
    logic             w_busy1_next;
    logic             w_busy2_next;

    // Qualify write and reserve: a hardwired register 0 can be neither written nor reserved.
    always_comb begin
        w_wr_en  = regwrite;
        w_rsv_en = reserve;
        if (ZERO_REG && (writereg == '0)) begin
            w_wr_en = 1'b0;
        end
        if (ZERO_REG && (reservereg == '0)) begin
            w_rsv_en = 1'b0;
        end
    end

    // Next scoreboard: the write clears first, then the reserve sets, so a new producer wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_en) begin
            w_busy_next[writereg] = 1'b0;
        end
        if (w_rsv_en) begin
            w_busy_next[reservereg] = 1'b1;
        end
    end

    // Read muxes: bypass the write in flight, and force zero on a hardwired register 0.
    always_comb begin
        w_zero1      = ZERO_REG && (readreg1 == '0);
        w_zero2      = ZERO_REG && (readreg2 == '0);
        w_data1_next = r_regs[readreg1];
        w_data2_next = r_regs[readreg2];
        if (w_wr_en && (writereg == readreg1)) begin
            w_data1_next = writedata;
        end
        if (w_wr_en && (writereg == readreg2)) begin
            w_data2_next = writedata;
        end
        if (w_zero1) begin
            w_data1_next = '0;
        end
        if (w_zero2) begin
            w_data2_next = '0;
        end
        // Busy flags follow the post-edge scoreboard so they agree with the bypassed data.
        w_busy1_next = w_zero1 ? 1'b0 : w_busy_next[readreg1];
        w_busy2_next = w_zero2 ? 1'b0 : w_busy_next[readreg2];
    end

    // Register storage: reset loads each register with its own index; otherwise apply the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= WIDTH'(i);
            end
        end else if (w_wr_en) begin
            r_regs[writereg] <= writedata;
        end
    end

    // Scoreboard and output flops; reset drops all pending reservations.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
            r_busy1 <= 1'b0;
            r_busy2 <= 1'b0;
        end else begin
            r_busy  <= w_busy_next;
            r_data1 <= w_data1_next;
            r_data2 <= w_data2_next;
            r_busy1 <= w_busy1_next;
            r_busy2 <= w_busy2_next;
        end
    end

    assign data1 = r_data1;
    assign data2 = r_data2;
    assign busy1 = r_busy1;
    assign busy2 = r_busy2;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives one shared stimulus stream into three configurations
// of regfile_sb (8x8, 8x8 with zero register, 16x16) and compares each against
// a behavioural register-file model every cycle, plus literal spot checks.
module tb_regfile_sb;

    localparam int NCFG = 3;
    localparam int SLOT = 34;            // {busy2, busy1, data2[15:0], data1[15:0]}
    localparam int EW   = NCFG * SLOT;

    // ---------------- clock / reset ----------------
    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        reset;
    logic        regwrite;
    logic        reserve;
    logic [3:0]  writereg;
    logic [3:0]  reservereg;
    logic [3:0]  readreg1;
    logic [3:0]  readreg2;
    logic [15:0] writedata;

    logic [7:0]  u0_data1, u0_data2;
    logic        u0_busy1, u0_busy2;
    logic [7:0]  u1_data1, u1_data2;
    logic        u1_busy1, u1_busy2;
    logic [15:0] u2_data1, u2_data2;
    logic        u2_busy1, u2_busy2;

    regfile_sb #(.WIDTH(8), .ADDRW(3), .ZERO_REG(1'b0)) u0 (
        .clk(clk), .reset(reset),
        .readreg1(readreg1[2:0]), .readreg2(readreg2[2:0]),
        .regwrite(regwrite), .writereg(writereg[2:0]), .writedata(writedata[7:0]),
        .reserve(reserve), .reservereg(reservereg[2:0]),
        .data1(u0_data1), .data2(u0_data2), .busy1(u0_busy1), .busy2(u0_busy2)
    );

    regfile_sb #(.WIDTH(8), .ADDRW(3), .ZERO_REG(1'b1)) u1 (
        .clk(clk), .reset(reset),
        .readreg1(readreg1[2:0]), .readreg2(readreg2[2:0]),
        .regwrite(regwrite), .writereg(writereg[2:0]), .writedata(writedata[7:0]),
        .reserve(reserve), .reservereg(reservereg[2:0]),
        .data1(u1_data1), .data2(u1_data2), .busy1(u1_busy1), .busy2(u1_busy2)
    );

    regfile_sb #(.WIDTH(16), .ADDRW(4), .ZERO_REG(1'b0)) u2 (
        .clk(clk), .reset(reset),
        .readreg1(readreg1), .readreg2(readreg2),
        .regwrite(regwrite), .writereg(writereg), .writedata(writedata),
        .reserve(reserve), .reservereg(reservereg),
        .data1(u2_data1), .data2(u2_data2), .busy1(u2_busy1), .busy2(u2_busy2)
    );

    // ---------------- counters / check helper ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cfg_w  [NCFG] = '{8, 8, 16};
    int cfg_aw [NCFG] = '{3, 3, 4};
    bit cfg_z  [NCFG] = '{1'b0, 1'b1, 1'b0};

    logic [15:0] m_reg  [NCFG][16];
    bit          m_busy [NCFG][16];
    logic [EW-1:0] exp_q[$];

    int          md, mwa, mrr, ma1, ma2;
    logic [15:0] mmask, md1, md2;
    logic        mb1, mb2;
    logic [EW-1:0] mexp;

    // Architectural view: apply this edge's write, clear and reserve, then read the new state.
    always @(posedge clk) begin
        mexp = '0;
        for (int c = 0; c < NCFG; c++) begin
            md    = 1 << cfg_aw[c];
            mmask = 16'((1 << cfg_w[c]) - 1);
            mwa   = int'(writereg) % md;
            mrr   = int'(reservereg) % md;
            ma1   = int'(readreg1) % md;
            ma2   = int'(readreg2) % md;
            if (reset) begin
                for (int i = 0; i < 16; i++) begin
                    m_reg[c][i]  = 16'(i % (1 << cfg_w[c]));
                    m_busy[c][i] = 1'b0;
                end
                md1 = '0; md2 = '0; mb1 = 1'b0; mb2 = 1'b0;
            end else begin
                if (regwrite && !(cfg_z[c] && mwa == 0)) begin
                    m_reg[c][mwa]  = writedata & mmask;
                    m_busy[c][mwa] = 1'b0;
                end
                if (reserve && !(cfg_z[c] && mrr == 0)) begin
                    m_busy[c][mrr] = 1'b1;
                end
                md1 = (cfg_z[c] && ma1 == 0) ? 16'h0 : m_reg[c][ma1];
                md2 = (cfg_z[c] && ma2 == 0) ? 16'h0 : m_reg[c][ma2];
                mb1 = (cfg_z[c] && ma1 == 0) ? 1'b0 : m_busy[c][ma1];
                mb2 = (cfg_z[c] && ma2 == 0) ? 1'b0 : m_busy[c][ma2];
            end
            mexp[c*SLOT +: SLOT] = {mb2, mb1, md2, md1};
        end
        exp_q.push_back(mexp);
    end

    // ---------------- scoreboard compare ----------------
    logic [EW-1:0] sb_exp, sb_act;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            sb_act = {u2_busy2, u2_busy1, u2_data2, u2_data1,
                      u1_busy2, u1_busy1, 8'h00, u1_data2, 8'h00, u1_data1,
                      u0_busy2, u0_busy1, 8'h00, u0_data2, 8'h00, u0_data1};
            for (int c = 0; c < NCFG; c++) begin
                chk($sformatf("cfg%0d data1", c), sb_act[c*SLOT +: 16], sb_exp[c*SLOT +: 16]);
                chk($sformatf("cfg%0d data2", c), sb_act[c*SLOT+16 +: 16], sb_exp[c*SLOT+16 +: 16]);
                chk($sformatf("cfg%0d busy1", c), 16'(sb_act[c*SLOT+32]), 16'(sb_exp[c*SLOT+32]));
                chk($sformatf("cfg%0d busy2", c), 16'(sb_act[c*SLOT+33]), 16'(sb_exp[c*SLOT+33]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic rw, input logic [3:0] wa,
                         input logic [15:0] wd, input logic rsv, input logic [3:0] rr,
                         input logic [3:0] a1, input logic [3:0] a2);
        reset      = rst;
        regwrite   = rw;
        writereg   = wa;
        writedata  = wd;
        reserve    = rsv;
        reservereg = rr;
        readreg1   = a1;
        readreg2   = a2;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; regwrite = 1'b0; reserve = 1'b0;
        writereg = '0; reservereg = '0; readreg1 = '0; readreg2 = '0; writedata = '0;

        // Reset defaults
        drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
        chk("reset data1", 16'(u0_data1), 16'h0);
        chk("reset busy1", 16'(u0_busy1), 16'h0);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd7);
        chk("default data1", 16'(u0_data1), 16'h05);
        chk("default data2", 16'(u0_data2), 16'h07);
        chk("default busy1", 16'(u0_busy1), 16'h0);
        chk("default busy2", 16'(u0_busy2), 16'h0);
        chk("default w16 data1", u2_data1, 16'h0005);

        // Write with bypass, then plain read-back
        drive(1'b0, 1'b1, 4'd3, 16'h00A5, 1'b0, 4'd0, 4'd3, 4'd2);
        chk("bypass data1", 16'(u0_data1), 16'h00A5);
        chk("bypass data2", 16'(u0_data2), 16'h0002);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd3);
        chk("readback data2", 16'(u0_data2), 16'h00A5);

        // Scoreboard reserve then clearing write with bypass
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd0, 4'd0);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd4, 4'd0);
        chk("reserved busy1", 16'(u0_busy1), 16'h1);
        drive(1'b0, 1'b1, 4'd4, 16'h003C, 1'b0, 4'd0, 4'd4, 4'd0);
        chk("clear data1", 16'(u0_data1), 16'h003C);
        chk("clear busy1", 16'(u0_busy1), 16'h0);

        // Write and reserve the same register: new producer wins
        drive(1'b0, 1'b1, 4'd6, 16'h0011, 1'b1, 4'd6, 4'd0, 4'd0);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd6, 4'd0);
        chk("wr+rsv data1", 16'(u0_data1), 16'h0011);
        chk("wr+rsv busy1", 16'(u0_busy1), 16'h1);

        // Register 0: hardwired in u1, ordinary in u0
        drive(1'b0, 1'b1, 4'd0, 16'h00FF, 1'b1, 4'd0, 4'd0, 4'd0);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
        chk("zero data1", 16'(u1_data1), 16'h0);
        chk("zero busy1", 16'(u1_busy1), 16'h0);
        chk("nozero data1", 16'(u0_data1), 16'h00FF);
        chk("nozero busy1", 16'(u0_busy1), 16'h1);

        // Reset mid-operation beats a same-cycle write and reserve
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 4'd0, 4'd0);
        drive(1'b0, 1'b1, 4'd5, 16'h0077, 1'b1, 4'd2, 4'd0, 4'd0);
        drive(1'b1, 1'b1, 4'd5, 16'h0099, 1'b1, 4'd3, 4'd5, 4'd1);
        chk("midreset data1", 16'(u0_data1), 16'h0);
        chk("midreset data2", 16'(u0_data2), 16'h0);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd1);
        chk("post-reset reg5", 16'(u0_data1), 16'h0005);
        chk("post-reset busy1", 16'(u0_busy2), 16'h0);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd15, 4'd2);
        chk("post-reset busy2", 16'(u0_busy2), 16'h0);
        chk("w16 reg15", u2_data1, 16'h000F);
        chk("w8 reg7", 16'(u0_data1), 16'h0007);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)),
                  16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end

        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
